// File: rtl/turn_arbiter.sv
// turn_arbiter: two-player shot sequencer between the debounced buttons and
// the game core. It accepts fire presses only from the player whose turn it is,
// latches the switch coordinate and presents it to the core through a valid/ack
// handshake. Out-of-turn presses are reported as fouls.
//
// Optional feature: define SHOT_TIMEOUT_EN to enable the per-turn timer. When
// the timer is enabled, a player who does not fire within TIMEOUT_CYCLES cycles
// forfeits the turn. When SHOT_TIMEOUT_EN is not defined, there is no timer
// logic, and o_timeout and o_time_left are tied to 0.
module turn_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 100
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_req_a,
    input  logic       i_req_b,
    input  logic [3:0] i_coord_in,
    input  logic       i_shot_ack,
    input  logic       i_game_over,
    output logic       o_shot_valid,
    output logic [3:0] o_shot_coord,
    output logic       o_shot_player,
    output logic       o_turn_player,
    output logic       o_foul,
    output logic       o_timeout,
    output logic [7:0] o_time_left,
    output logic [2:0] o_state_code
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_TURN  = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;

    // Value loaded into the timer at the start of every turn.
    localparam logic [7:0] TL_RELOAD = 8'(TIMEOUT_CYCLES - 1);

    logic [2:0] r_state;
    logic       r_prev_start;
    logic       r_prev_a;
    logic       r_prev_b;
    logic       r_turn;
    logic       r_shot_valid;
    logic [3:0] r_shot_coord;
    logic       r_shot_player;
    logic       r_foul;

    logic [2:0] w_state_d;
    logic       w_turn_d;
    logic       w_shot_valid_d;
    logic [3:0] w_shot_coord_d;
    logic       w_shot_player_d;
    logic       w_foul_d;

    logic       w_edge_start;
    logic       w_edge_a;
    logic       w_edge_b;
    logic       w_edge_own;
    logic       w_edge_other;

`ifdef SHOT_TIMEOUT_EN
    logic [7:0] r_time_left;
    logic       r_timeout;
    logic [7:0] w_time_left_d;
    logic       w_timeout_d;
`else
    logic       w_unused_reload;
`endif

    // Rising-edge detection. The previous-value registers reset high so a
    // button held through reset does not fire.
    always_comb begin
        w_edge_start = i_start & ~r_prev_start;
        w_edge_a     = i_req_a & ~r_prev_a;
        w_edge_b     = i_req_b & ~r_prev_b;
        w_edge_own   = r_turn ? w_edge_b : w_edge_a;
        w_edge_other = r_turn ? w_edge_a : w_edge_b;
    end

    // Next-state logic for the turn sequencer.
    always_comb begin
        w_state_d       = r_state;
        w_turn_d        = r_turn;
        w_shot_valid_d  = r_shot_valid;
        w_shot_coord_d  = r_shot_coord;
        w_shot_player_d = r_shot_player;
        w_foul_d        = 1'b0;
`ifdef SHOT_TIMEOUT_EN
        w_time_left_d   = r_time_left;
        w_timeout_d     = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_edge_start) begin
                    w_state_d = ST_TURN;
                    w_turn_d  = 1'b0;
`ifdef SHOT_TIMEOUT_EN
                    w_time_left_d = TL_RELOAD;
`endif
                end
            end
            ST_TURN: begin
                // A simultaneous press by the other player still counts as a foul.
                w_foul_d = w_edge_other;
                if (w_edge_own) begin
                    w_state_d       = ST_ISSUE;
                    w_shot_valid_d  = 1'b1;
                    w_shot_coord_d  = i_coord_in;
                    w_shot_player_d = r_turn;
                end
`ifdef SHOT_TIMEOUT_EN
                else if (r_time_left == 8'd0) begin
                    w_timeout_d   = 1'b1;
                    w_turn_d      = ~r_turn;
                    w_time_left_d = TL_RELOAD;
                end else begin
                    w_time_left_d = r_time_left - 8'd1;
                end
`endif
            end
            ST_ISSUE: begin
                if (i_shot_ack) begin
                    w_shot_valid_d = 1'b0;
                    if (i_game_over) begin
                        w_state_d = ST_DONE;
`ifdef SHOT_TIMEOUT_EN
                        w_time_left_d = 8'd0;
`endif
                    end else begin
                        w_state_d = ST_TURN;
                        w_turn_d  = ~r_turn;
`ifdef SHOT_TIMEOUT_EN
                        w_time_left_d = TL_RELOAD;
`endif
                    end
                end
            end
            ST_DONE: begin
                if (w_edge_start) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d      = ST_IDLE;
                w_shot_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight shot.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_prev_start  <= 1'b1;
            r_prev_a      <= 1'b1;
            r_prev_b      <= 1'b1;
            r_turn        <= 1'b0;
            r_shot_valid  <= 1'b0;
            r_shot_coord  <= 4'd0;
            r_shot_player <= 1'b0;
            r_foul        <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_prev_start  <= i_start;
            r_prev_a      <= i_req_a;
            r_prev_b      <= i_req_b;
            r_turn        <= w_turn_d;
            r_shot_valid  <= w_shot_valid_d;
            r_shot_coord  <= w_shot_coord_d;
            r_shot_player <= w_shot_player_d;
            r_foul        <= w_foul_d;
        end
    end

`ifdef SHOT_TIMEOUT_EN
    // Turn timer registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_time_left <= 8'd0;
            r_timeout   <= 1'b0;
        end else begin
            r_time_left <= w_time_left_d;
            r_timeout   <= w_timeout_d;
        end
    end

    assign o_time_left = r_time_left;
    assign o_timeout   = r_timeout;
`else
    assign w_unused_reload = ^TL_RELOAD;
    assign o_time_left     = 8'd0;
    assign o_timeout       = 1'b0;
`endif

    assign o_shot_valid  = r_shot_valid;
    assign o_shot_coord  = r_shot_coord;
    assign o_shot_player = r_shot_player;
    assign o_turn_player = r_turn;
    assign o_foul        = r_foul;
    assign o_state_code  = r_state;

endmodule

// File: tb/tb_turn_arbiter.sv
// Directed bench for turn_arbiter. Expected shots go into a scoreboard queue
// when the press is driven, and they are popped when shot_valid is observed.
// Timer checks are built only when SHOT_TIMEOUT_EN is defined.
module tb_turn_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       req_a;
    logic       req_b;
    logic [3:0] coord_in;
    logic       shot_ack;
    logic       game_over;
    logic       shot_valid;
    logic [3:0] shot_coord;
    logic       shot_player;
    logic       turn_player;
    logic       foul;
    logic       timeout;
    logic [7:0] time_left;
    logic [2:0] state_code;

    int checks   = 0;
    int failures = 0;

    // Each entry is {player, coord}.
    logic [4:0] sb_q[$];

    turn_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
        .i_coord_in   (coord_in),
        .i_shot_ack   (shot_ack),
        .i_game_over  (game_over),
        .o_shot_valid (shot_valid),
        .o_shot_coord (shot_coord),
        .o_shot_player(shot_player),
        .o_turn_player(turn_player),
        .o_foul       (foul),
        .o_timeout    (timeout),
        .o_time_left  (time_left),
        .o_state_code (state_code)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A shot should be presented now: compare it against the scoreboard head.
    task automatic chk_shot(input string tag);
        logic [4:0] exp;
        chk({tag, ".valid"}, 32'(shot_valid), 32'd1);
        if (sb_q.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'(sb_q.size()), 32'd1);
        end else begin
            exp = sb_q.pop_front();
            chk({tag, ".coord"}, 32'(shot_coord), 32'(exp[3:0]));
            chk({tag, ".player"}, 32'(shot_player), 32'(exp[4]));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".valid"}, 32'(shot_valid), 32'd0);
        chk({tag, ".coord"}, 32'(shot_coord), 32'd0);
        chk({tag, ".player"}, 32'(shot_player), 32'd0);
        chk({tag, ".turn"}, 32'(turn_player), 32'd0);
        chk({tag, ".foul"}, 32'(foul), 32'd0);
        chk({tag, ".timeout"}, 32'(timeout), 32'd0);
        chk({tag, ".tl"}, 32'(time_left), 32'd0);
        chk({tag, ".state"}, 32'(state_code), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; req_a = 1'b1; req_b = 1'b0;
        coord_in = 4'd0; shot_ack = 1'b0; game_over = 1'b0;
        tick(); tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();
        chk("idle_after_rst.state", 32'(state_code), 32'd0);

        // Start the game with req_a still held from reset.
        start = 1'b1;
        tick();
        chk("start.state", 32'(state_code), 32'd1);
        chk("start.turn", 32'(turn_player), 32'd0);
`ifdef SHOT_TIMEOUT_EN
        chk("start.tl", 32'(time_left), 32'd3);
`endif
        start = 1'b0;
        tick();
        chk("held_a.no_shot", 32'(shot_valid), 32'd0);
        req_a = 1'b0;
        tick();
        chk("released_a.no_shot", 32'(shot_valid), 32'd0);

        // A fires at coordinate 9.
        req_a = 1'b1; coord_in = 4'b1001;
        sb_q.push_back({1'b0, 4'b1001});
        tick();
        chk_shot("shot_a");
        chk("shot_a.state", 32'(state_code), 32'd2);
        req_a = 1'b0; coord_in = 4'b0000;
        tick();
        chk("issue_hold.coord", 32'(shot_coord), 32'd9);
        req_b = 1'b1;
        tick();
        chk("issue_ignore_b.foul", 32'(foul), 32'd0);
        chk("issue_ignore_b.valid", 32'(shot_valid), 32'd1);
        shot_ack = 1'b1; req_b = 1'b0;
        tick();
        chk("ack_a.valid", 32'(shot_valid), 32'd0);
        chk("ack_a.turn", 32'(turn_player), 32'd1);
        chk("ack_a.state", 32'(state_code), 32'd1);
`ifdef SHOT_TIMEOUT_EN
        chk("ack_a.tl", 32'(time_left), 32'd3);
`endif
        shot_ack = 1'b0;

        // Out-of-turn press by A during B's turn.
        req_a = 1'b1;
        tick();
        chk("foul_a.foul", 32'(foul), 32'd1);
        chk("foul_a.valid", 32'(shot_valid), 32'd0);
        req_a = 1'b0;
        tick();
        chk("foul_a.one_cycle", 32'(foul), 32'd0);

        // Both press during B's turn: B's shot issues and a foul pulses.
        req_a = 1'b1; req_b = 1'b1; coord_in = 4'b0110;
        sb_q.push_back({1'b1, 4'b0110});
        tick();
        chk_shot("both_b");
        chk("both_b.foul", 32'(foul), 32'd1);
        shot_ack = 1'b1; req_a = 1'b0; req_b = 1'b0;
        tick();
        chk("ack_b.turn", 32'(turn_player), 32'd0);
        chk("ack_b.foul", 32'(foul), 32'd0);
        shot_ack = 1'b0;
        tick();

        // Both press during A's turn.
        req_a = 1'b1; req_b = 1'b1; coord_in = 4'hC;
        sb_q.push_back({1'b0, 4'hC});
        tick();
        chk_shot("both_a");
        chk("both_a.foul", 32'(foul), 32'd1);
        shot_ack = 1'b1; req_a = 1'b0; req_b = 1'b0;
        tick();
        chk("ack_c.turn", 32'(turn_player), 32'd1);
        shot_ack = 1'b0;

`ifdef SHOT_TIMEOUT_EN
        // B sits idle and forfeits the turn TIMEOUT_CYCLES cycles after entry.
        tick(); tick(); tick();
        chk("tmo.tl_zero", 32'(time_left), 32'd0);
        chk("tmo.not_yet", 32'(timeout), 32'd0);
        tick();
        chk("tmo.pulse", 32'(timeout), 32'd1);
        chk("tmo.turn", 32'(turn_player), 32'd0);
        chk("tmo.tl_reload", 32'(time_left), 32'd3);
        tick();
        chk("tmo.one_cycle", 32'(timeout), 32'd0);
        tick(); tick();
        chk("tmo2.tl_zero", 32'(time_left), 32'd0);
        // A fires on the expiry cycle; the shot wins over the timeout.
        req_a = 1'b1; coord_in = 4'b0011;
        sb_q.push_back({1'b0, 4'b0011});
        tick();
        chk_shot("expiry_a");
        chk("expiry_a.no_timeout", 32'(timeout), 32'd0);
`else
        // Without the timer, the turn waits indefinitely.
        for (int i = 0; i < 6; i++) tick();
        chk("notmr.state", 32'(state_code), 32'd1);
        chk("notmr.turn", 32'(turn_player), 32'd1);
        chk("notmr.timeout", 32'(timeout), 32'd0);
        chk("notmr.tl", 32'(time_left), 32'd0);
        req_b = 1'b1; coord_in = 4'b0011;
        sb_q.push_back({1'b1, 4'b0011});
        tick();
        chk_shot("late_b");
`endif

        // Game over on ack.
        shot_ack = 1'b1; game_over = 1'b1; req_a = 1'b0; req_b = 1'b0;
        tick();
        chk("done.state", 32'(state_code), 32'd3);
        chk("done.valid", 32'(shot_valid), 32'd0);
        chk("done.tl", 32'(time_left), 32'd0);
        shot_ack = 1'b0; game_over = 1'b0;
        req_a = 1'b1; req_b = 1'b1;
        tick();
        chk("done_ignore.state", 32'(state_code), 32'd3);
        chk("done_ignore.valid", 32'(shot_valid), 32'd0);
        chk("done_ignore.foul", 32'(foul), 32'd0);
        start = 1'b1;
        tick();
        chk("done_start.state", 32'(state_code), 32'd0);
        start = 1'b0;
        tick();

        // New game, then reset while a shot is in flight.
        start = 1'b1; req_a = 1'b0; req_b = 1'b0;
        tick();
        chk("restart.state", 32'(state_code), 32'd1);
        chk("restart.turn", 32'(turn_player), 32'd0);
        start = 1'b0;
        req_a = 1'b1; coord_in = 4'b0101;
        sb_q.push_back({1'b0, 4'b0101});
        tick();
        chk_shot("pre_rst");
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        #1;
        rst = 1'b0; shot_ack = 1'b1;
        tick();
        chk("post_rst_ack.valid", 32'(shot_valid), 32'd0);
        chk("post_rst_ack.state", 32'(state_code), 32'd0);
        chk("post_rst_ack.turn", 32'(turn_player), 32'd0);
        shot_ack = 1'b0;
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
